// File: rtl/ts_queue.sv
// Timestamp capture queue: circular buffer of 128-bit entries filtered by PTP messageType mask.
// Optional dropped-on-full counter is built when TS_QUEUE_DROP_CNT_EN is defined.
module ts_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         q_wr_en_in,
    input  logic [3:0]   q_msgid_in,
    input  logic [127:0] q_data_in,
    input  logic [7:0]   q_ptp_msgid_mask_in,
    input  logic         q_rst_in,
    input  logic         q_rd_en_in,
    output logic [127:0] q_data_out,
    output logic [7:0]   q_stat_out,
    output logic [15:0]  q_drop_cnt_out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [127:0]        mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, count;
    logic                full, empty, type_ok, pop, push, drop, ovf;

    function automatic logic [4:0] sat_count(input logic [DEPTH_LOG2:0] c);
        logic [31:0] ext;
        ext = 32'(c);
        if (ext > 32'd31) return 5'd31;
        return ext[4:0];
    endfunction

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}});
    // messageType 8..15 has no mask bit and is never stored
    assign type_ok = q_wr_en_in && !q_msgid_in[3]
                     && q_ptp_msgid_mask_in[q_msgid_in[2:0]] && !q_rst_in;
    assign pop     = q_rd_en_in && !empty && !q_rst_in;
    assign push    = type_ok && (!full || pop);
    assign drop    = type_ok && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= q_data_in;
    end

    // Outputs reflect the pointers settled at the previous edge, giving one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ovf        <= 1'b0;
            q_data_out <= '0;
            q_stat_out <= '0;
        end else if (q_rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ovf        <= 1'b0;
            q_data_out <= '0;
            q_stat_out <= '0;
        end else begin
            wr_ptr     <= wr_ptr + (DEPTH_LOG2 + 1)'(push);
            rd_ptr     <= rd_ptr + (DEPTH_LOG2 + 1)'(pop);
            ovf        <= ovf | drop;
            q_data_out <= empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
            q_stat_out <= {ovf, 2'b00, sat_count(count)};
        end
    end

`ifdef TS_QUEUE_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               q_drop_cnt_out <= '0;
        else if (q_rst_in)                        q_drop_cnt_out <= '0;
        else if (drop && q_drop_cnt_out != 16'hFFFF) q_drop_cnt_out <= q_drop_cnt_out + 16'd1;
    end
`else
    assign q_drop_cnt_out = '0;
`endif

endmodule

// File: tb/tb_ts_queue.sv
// Randomized and directed bench for ts_queue against a queue-based reference model.
module tb_ts_queue;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr = 1'b0, rd = 1'b0, qr = 1'b0;
    logic [3:0]   id = '0;
    logic [127:0] din = '0;
    logic [7:0]   mask = '0;
    logic [127:0] q_data_out;
    logic [7:0]   q_stat_out;
    logic [15:0]  q_drop_cnt_out;

    ts_queue #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst_n(rst_n),
        .q_wr_en_in(wr), .q_msgid_in(id), .q_data_in(din),
        .q_ptp_msgid_mask_in(mask), .q_rst_in(qr), .q_rd_en_in(rd),
        .q_data_out(q_data_out), .q_stat_out(q_stat_out), .q_drop_cnt_out(q_drop_cnt_out)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] mq[$];
    bit           m_ovf = 1'b0;
    int           m_drop = 0;
    logic [127:0] e_data = '0;
    logic [7:0]   e_stat = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stat_of(input bit o, input int n);
        int c;
        c = (n > 31) ? 31 : n;
        return {o, 2'b00, 5'(c)};
    endfunction

    function automatic int exp_drop();
`ifdef TS_QUEUE_DROP_CNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_data"}, q_data_out, e_data);
        chk({tag, "_stat"}, 128'(q_stat_out), 128'(e_stat));
        chk({tag, "_drop"}, 128'(q_drop_cnt_out), 128'(exp_drop()));
    endtask

    // Drive one cycle, advance the model, check after the edge
    task automatic cyc(input bit w, input logic [3:0] i, input logic [127:0] d,
                       input bit r, input bit f);
        logic [127:0] nd;
        logic [7:0]   ns;
        bit           ok, was_full, popv;
        wr = w; id = i; din = d; rd = r; qr = f;
        nd = (mq.size() == 0) ? '0 : mq[0];
        ns = stat_of(m_ovf, mq.size());
        if (f) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            e_data = '0;
            e_stat = '0;
        end else begin
            ok       = w && (i < 4'd8) && mask[i[2:0]];
            was_full = (mq.size() == DEPTH);
            popv     = r && (mq.size() > 0);
            if (popv) void'(mq.pop_front());
            if (ok) begin
                if (!was_full || popv) mq.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            e_data = nd;
            e_stat = ns;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
        wr = 1'b0; rd = 1'b0; qr = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        cyc(1'b0, 4'd0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [127:0] a5, nv;
        a5 = {16{8'hA5}};
        nv = {4{32'hC0FFEE00}};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", q_data_out, '0);
        chk("rst_stat", 128'(q_stat_out), 128'h0);
        chk("rst_drop", 128'(q_drop_cnt_out), 128'h0);
        rst_n = 1'b1;

        // Mask filter: only messageType 0 stored
        mask = 8'h01;
        cyc(1'b1, 4'd0, a5, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 128'h1111, 1'b0, 1'b0);
        cyc(1'b1, 4'd9, 128'h9999, 1'b0, 1'b0);
        idle();
        chk("mask_data", q_data_out, a5);
        chk("mask_stat", 128'(q_stat_out), 128'h01);

        // Fill past capacity
        flush();
        mask = 8'hFF;
        for (int k = 0; k < 17; k++) cyc(1'b1, 4'(k % 8), 128'(k + 100), 1'b0, 1'b0);
        idle();
        chk("full_stat", 128'(q_stat_out), 128'h90);
        chk("full_head", q_data_out, 128'(100));
`ifdef TS_QUEUE_DROP_CNT_EN
        chk("full_drop", 128'(q_drop_cnt_out), 128'h1);
`else
        chk("full_drop", 128'(q_drop_cnt_out), 128'h0);
`endif

        // Write and pop together while full
        flush();
        for (int k = 0; k < 16; k++) cyc(1'b1, 4'd3, 128'(k + 200), 1'b0, 1'b0);
        cyc(1'b1, 4'd2, nv, 1'b1, 1'b0);
        idle();
        chk("wrpop_full_stat", 128'(q_stat_out), 128'h10);
        for (int k = 0; k < 16; k++) cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        idle();
        chk("drain_stat", 128'(q_stat_out), 128'h00);

        // Pop on empty, then write+pop on empty
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        idle();
        chk("empty_pop_stat", 128'(q_stat_out), 128'h00);
        chk("empty_pop_data", q_data_out, '0);
        cyc(1'b1, 4'd5, 128'h55, 1'b1, 1'b0);
        idle();
        chk("empty_wrpop_stat", 128'(q_stat_out), 128'h01);

        // Flush coincident with write
        flush();
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'd4, 128'(k + 300), 1'b0, 1'b0);
        cyc(1'b1, 4'd4, 128'h777, 1'b0, 1'b1);
        chk("flush_stat", 128'(q_stat_out), 128'h00);
        chk("flush_data", q_data_out, '0);
        idle();
        chk("flush_stat2", 128'(q_stat_out), 128'h00);

        // Pointer wrap with alternating write/pop
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 4'd6, 128'(k + 1000), 1'b0, 1'b0);
            cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        end
        idle();

        // Asynchronous reset mid-operation
        for (int k = 0; k < 5; k++) cyc(1'b1, 4'd7, 128'(k + 500), 1'b0, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0; m_drop = 0; e_data = '0; e_stat = '0;
        chk("async_rst_data", q_data_out, '0);
        chk("async_rst_stat", 128'(q_stat_out), 128'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 4'd0, 128'hBEEF, 1'b0, 1'b0);
        idle();
        chk("post_rst_data", q_data_out, 128'hBEEF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          w, r, f;
            logic [3:0]  i;
            if ($urandom_range(0, 199) == 0) mask = 8'($urandom);
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < (n < 1500 ? 40 : 55));
            f = ($urandom_range(0, 149) == 0);
            i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            cyc(w, i, {$urandom, $urandom, $urandom, $urandom}, r, f);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
